// File: rtl/gap_pkg.sv
// Shared widths, state encoding and output saturation for the global average pool.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package gap_pkg;

  localparam int DW              = `DATA_WIDTH;
  localparam int CHANNEL_NUM_DEF = 512;
  localparam int PIX_NUM_DEF     = 49;
  localparam int LOG2PIX_NUM_DEF = 6;
  localparam int RECIP_DEF       = 1337;  // round(2^16 / 49)
  localparam int SHIFT_DEF       = 16;

  // A 49-pixel sum of DW-bit values needs LOG2PIX_NUM bits of headroom.
  localparam int ACC_W  = DW + LOG2PIX_NUM_DEF;
  localparam int PROD_W = ACC_W + SHIFT_DEF + 2;

  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(2**(DW-1) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(2**(DW-1)));

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    SCALE,
    OUT,
    WAIT_VS
  } state_t;

  // Clamp a rounded, already-shifted product into the DW-bit signed output range.
  function automatic logic [DW-1:0] gap_sat(input logic signed [PROD_W-1:0] v);
    logic [DW-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[DW-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[DW-1:0];
    end else begin
      r = v[DW-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/gap_channel.sv
// One channel of the average pool: accumulate, multiply by reciprocal, round and saturate.
// Latency: result registered one cycle after scale_en, i.e. at the out_en edge.
// Backpressure: none; strobes come from the top-level FSM every cycle.
module gap_channel
  import gap_pkg::*;
#(
  parameter int RECIP = RECIP_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          acc_en,
  input  logic          scale_en,
  input  logic          out_en,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out
);

  localparam logic signed [PROD_W-1:0] RECIP_S = PROD_W'(RECIP);
  localparam logic signed [PROD_W-1:0] HALF    = PROD_W'(1) << (SHIFT - 1);

  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_base;
  logic signed [PROD_W-1:0] prod_q, prod_d, rnd;
  logic [DW-1:0]            out_q, out_d;

  // Next-state: clear has priority, so a beat arriving with clr becomes the first term.
  always_comb begin
    acc_base = clr ? '0 : acc_q;
    acc_d    = acc_en ? (acc_base + ACC_W'($signed(data_in))) : acc_base;
    prod_d   = scale_en ? (PROD_W'(acc_q) * RECIP_S) : prod_q;
    rnd      = (prod_q + HALF) >>> SHIFT;
    out_d    = out_en ? gap_sat(rnd) : out_q;
  end

  // Channel state registers; an async reset drops any partial sum at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      prod_q <= '0;
      out_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      prod_q <= prod_d;
      out_q  <= out_d;
    end
  end

  assign data_out = out_q;

endmodule

// File: rtl/global_avgpool_layer8.sv
// Global average pool over a 7x7 frame of 512-channel pixels, scaled by a 1/49 reciprocal.
// Latency: data_e_out rises 2 cycles after the edge sampling the last pixel of a frame.
// Backpressure: none; unexpected beats are dropped and flagged on sticky frame_err.
module global_avgpool_layer8
  import gap_pkg::*;
#(
  parameter int CHANNEL_NUM = CHANNEL_NUM_DEF,
  parameter int PIX_NUM     = PIX_NUM_DEF,
  parameter int LOG2PIX_NUM = LOG2PIX_NUM_DEF,
  parameter int RECIP       = RECIP_DEF,
  parameter int SHIFT       = SHIFT_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic                      vs,
  input  logic                      data_e,
  input  logic [CHANNEL_NUM*DW-1:0] data_in,
  output logic [CHANNEL_NUM*DW-1:0] data_out,
  output logic                      data_e_out,
  output logic                      frame_err
);

  localparam logic [LOG2PIX_NUM-1:0] CNT_LAST = LOG2PIX_NUM'(PIX_NUM - 1);
  localparam logic [LOG2PIX_NUM-1:0] CNT_ONE  = LOG2PIX_NUM'(1);

  state_t                 state_q, state_d;
  logic [LOG2PIX_NUM-1:0] cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   vld_q, vld_d;
  logic                   pend_q, pend_d;   // vs seen during SCALE: restart after OUT
  logic                   clr, acc_en, scale_en, out_en;

  // FSM next-state and per-cycle channel strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    vld_d    = 1'b0;
    pend_d   = 1'b0;
    clr      = 1'b0;
    acc_en   = 1'b0;
    scale_en = 1'b0;
    out_en   = 1'b0;
    if (!mode) begin
      state_d = IDLE;
      cnt_d   = '0;
      err_d   = 1'b0;
      clr     = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          clr = 1'b1;
          if (vs) begin
            state_d = ACCUM;
            cnt_d   = '0;
            if (data_e) begin
              acc_en = 1'b1;
              cnt_d  = CNT_ONE;
            end
          end
        end
        ACCUM: begin
          if (vs) begin
            // A new frame start with pixels already summed means the old frame was cut short.
            if (cnt_q != '0) err_d = 1'b1;
            clr   = 1'b1;
            cnt_d = '0;
            if (data_e) begin
              acc_en = 1'b1;
              cnt_d  = CNT_ONE;
            end
          end else if (data_e) begin
            acc_en = 1'b1;
            cnt_d  = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) state_d = SCALE;
          end
        end
        SCALE: begin
          scale_en = 1'b1;
          pend_d   = vs;
          state_d  = OUT;
          if (data_e) err_d = 1'b1;
        end
        OUT: begin
          out_en = 1'b1;
          vld_d  = 1'b1;
          clr    = 1'b1;
          cnt_d  = '0;
          state_d = (vs || pend_q) ? ACCUM : WAIT_VS;
          if (vs && data_e) begin
            acc_en = 1'b1;
            cnt_d  = CNT_ONE;
          end else if (data_e) begin
            err_d = 1'b1;
          end
        end
        WAIT_VS: begin
          if (vs) begin
            state_d = ACCUM;
            clr     = 1'b1;
            cnt_d   = '0;
            if (data_e) begin
              acc_en = 1'b1;
              cnt_d  = CNT_ONE;
            end
          end else if (data_e) begin
            err_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          clr     = 1'b1;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      pend_q  <= pend_d;
    end
  end

  for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_ch
    gap_channel #(
      .RECIP (RECIP),
      .SHIFT (SHIFT)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .acc_en   (acc_en),
      .scale_en (scale_en),
      .out_en   (out_en),
      .data_in  (data_in[c*DW +: DW]),
      .data_out (data_out[c*DW +: DW])
    );
  end

  assign data_e_out = vld_q;
  assign frame_err  = err_q;

endmodule

// File: doc/global_avgpool_layer8.md
Name: global_avgpool_layer8

Overview:
- Global average pooling stage directly downstream of layer 7's RPReLU output.
- Consumes the 512-channel pixel stream (7x7 = 49 pixels per frame, one pixel per data_e beat).
- Accumulates each channel over one frame, then scales the sum by 1/49 with a fixed-point reciprocal.
- Emits one 512-channel averaged vector per frame, with a one-cycle data_e_out pulse, to the classifier stage.

Parameters:
- CHANNEL_NUM, 512, number of channels per pixel
- PIX_NUM, 49, pixels per frame (post-stride FM width squared)
- LOG2PIX_NUM, 6, ceil(log2(PIX_NUM)); sets counter width and accumulator headroom
- RECIP, 1337, round(2^SHIFT / PIX_NUM), unsigned
- SHIFT, 16, fixed-point fraction bits of RECIP

Ports:
- clk, input, 1, system clock
- rst_n, input, 1, asynchronous active-low reset
- mode, input, 1, LOW = parameter reload (block idle), HIGH = calculate
- vs, input, 1, vsync pulse; marks frame start
- data_e, input, 1, pixel valid from layer 7
- data_in, input, signed `DATA_WIDTH x [CHANNEL_NUM], layer 7 data_out
- data_out, output, signed `DATA_WIDTH x [CHANNEL_NUM], averaged vector
- data_e_out, output, 1, single-cycle valid for data_out
- frame_err, output, 1, sticky: frame aborted or excess pixels received

Behaviour:
- Reset: all accumulators, pixel counter, data_out and data_e_out = 0; frame_err = 0; state = IDLE.
- Reset mid-frame: the partial sum is discarded immediately.
- FSM states:
  - IDLE: entered on reset or whenever mode=0, from any state; accumulators are cleared. Go to ACCUM on a vs sampled while mode=1.
  - ACCUM: on each data_e, acc[c] += sign-extended data_in[c] and cnt++. When the beat with cnt==PIX_NUM-1 is accepted, go to SCALE.
  - SCALE: one cycle; prod[c] = acc[c] * RECIP is registered.
  - OUT: one cycle; data_out[c] = sat((prod[c] + 2^(SHIFT-1)) >>> SHIFT) is registered and data_e_out=1. Accumulators and cnt are cleared. Go to WAIT_VS.
  - WAIT_VS: data_out holds; go to ACCUM on vs.
- Latency: data_e_out rises 2 cycles after the clock edge that samples the 49th data_e.
- data_out holds its value until the next OUT cycle. data_e_out is high for exactly 1 cycle.
- Widths:
  - acc is `DATA_WIDTH + LOG2PIX_NUM signed, which cannot overflow.
  - prod is acc width + SHIFT + 2 signed.
  - The rounding shift is arithmetic (floor of value + 0.5).
  - Saturation range is [-2^(`DATA_WIDTH-1), 2^(`DATA_WIDTH-1)-1].
- vs in ACCUM with cnt>0 (aborted frame): set frame_err, clear acc/cnt, stay in ACCUM. No output is produced for the aborted frame.
- vs with data_e in the same cycle: the clear takes priority and that beat becomes pixel 0 of the new frame (cnt=1).
- data_e in SCALE, OUT or WAIT_VS without vs: beat ignored, frame_err set.
- frame_err is cleared only by reset or mode=0.
- vs arriving during SCALE or OUT: the pending result still completes; the FSM then enters ACCUM instead of WAIT_VS.
- mode falling during SCALE or OUT: abort; data_e_out does not pulse.

Decomposition:
- Package gap_pkg holds:
  - localparams ACC_W and PROD_W;
  - the RECIP/SHIFT defaults;
  - the state typedef (IDLE, ACCUM, SCALE, OUT, WAIT_VS);
  - the saturate function.
- Sub-module gap_channel handles one channel: acc/prod/out registers driven by the shared clr/acc_en/scale_en/out_en strobes. It is generated CHANNEL_NUM times.
- The top level holds the FSM, the pixel counter and frame_err.

Test Plan:
- mode=1, vs, then 49 beats with every channel = 3 -> after 2 cycles data_e_out=1 for 1 cycle, all data_out=3; frame_err=0.
- 49 beats all -128 -> data_out=-128 (sum -6272, rounded -127.45 floors to -128). 49 beats all 127 -> data_out=127.
- Channel 0: 24 beats of 10 then 25 beats of 0; channel 1: alternating +5/-5 starting at +5 -> ch0=5 (240*1337 rounds to 5), ch1=0 (sum 5).
- vs after 20 beats, then a full 49-beat frame of 7 -> frame_err=1, exactly one data_e_out, data_out=7.
- vs and data_e in the same cycle, then 48 more beats of 2 -> output 2 with latency 2. A 50th beat in WAIT_VS -> frame_err=1 and data_out unchanged.
- rst_n low for 1 cycle after 30 beats -> all outputs 0 asynchronously. Next vs plus 49 beats -> correct average. mode=0 during SCALE -> no data_e_out.
